adder_share_arb: RTL

ADDER_SHARE_ARB -- requirements
Module: adder_share_arb

---
 rtl/adder_share_arb.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/adder_share_arb.sv
// Two-requester adder sharing one ripple-carry adder; result registered, visible 1 cycle after accept.
// Holds one response; requests stall while it is unconsumed, and consume+accept in one edge gives no bubble.
module adder_share_arb #(
  parameter int N  = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [N-1:0]  req0_a,
  input  logic [N-1:0]  req0_b,
  input  logic          req0_cin,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [N-1:0]  req1_a,
  input  logic [N-1:0]  req1_b,
  input  logic          req1_cin,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [N-1:0]  rsp_sum,
  output logic          rsp_cout,
  output logic          rsp_id,
  output logic [CW-1:0] cnt0,
  output logic [CW-1:0] cnt1
);

  typedef struct packed {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
  } op_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic          last_grant_q;
  logic          grant_vld;
  logic          grant_id;
  logic          slot_free;
  logic          accept;
  logic          consume;
  op_t           op0, op1, op_sel;
  logic [N-1:0]  sum_w;
  logic          cout_w;
  logic [N-1:0]  sum_q;
  logic          cout_q;
  logic          id_q;
  logic [CW-1:0] cnt0_q, cnt1_q;

  assign op0 = {req0_a, req0_b, req0_cin};
  assign op1 = {req1_a, req1_b, req1_cin};

  // On contention the requester that did not win last time gets the slot.
  always_comb begin
    grant_vld = req0_valid | req1_valid;
    grant_id  = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant_q;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  assign rsp_valid  = (state_q == FULL);
  assign consume    = rsp_valid & rsp_ready;
  assign slot_free  = (state_q == EMPTY) | consume;
  // rst_n gating keeps both readies low for the whole reset pulse.
  assign req0_ready = rst_n & slot_free & grant_vld & ~grant_id;
  assign req1_ready = rst_n & slot_free & grant_vld &  grant_id;
  assign accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);

  assign op_sel = grant_id ? op1 : op0;

  adder_share_arb_rca #(.N(N)) u_rca (
    .a    (op_sel.a),
    .b    (op_sel.b),
    .cin  (op_sel.cin),
    .sum  (sum_w),
    .cout (cout_w)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: begin
        if (accept) state_d = FULL;
      end
      FULL: begin
        if (accept) begin
          state_d = FULL;
        end else if (consume) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Result fields only move on accept, so they hold after a plain consume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q        <= '0;
      cout_q       <= 1'b0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
    end else if (accept) begin
      sum_q        <= sum_w;
      cout_q       <= cout_w;
      id_q         <= grant_id;
      last_grant_q <= grant_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (consume) begin
      if (!id_q && (cnt0_q != {CW{1'b1}})) cnt0_q <= cnt0_q + CW'(1);
      if ( id_q && (cnt1_q != {CW{1'b1}})) cnt1_q <= cnt1_q + CW'(1);
    end
  end

  assign rsp_sum  = sum_q;
  assign rsp_cout = cout_q;
  assign rsp_id   = id_q;
  assign cnt0     = cnt0_q;
  assign cnt1     = cnt1_q;

endmodule

// N-bit ripple-carry adder built from per-bit full-adder equations.
module adder_share_arb_rca #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  always_comb begin
    logic c;
    sum = '0;
    c   = cin;
    for (int i = 0; i < N; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule
